// File: rtl/otter_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency reads and
// buffers returned words with their PCs in a DEPTH-entry FIFO drained by decode.
module otter_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 14,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     REDIRECT,
    input  logic [XLEN-1:0]          REDIRECT_PC,
    output logic                     IMEM_RDEN,
    output logic [ADDR_W-1:0]        IMEM_ADDR,
    input  logic [XLEN-1:0]          IMEM_DOUT,
    output logic                     DE_VALID,
    input  logic                     DE_READY,
    output logic [XLEN-1:0]          DE_IR,
    output logic [XLEN-1:0]          DE_PC,
    output logic [XLEN-1:0]          DE_PC_INC,
    output logic [$clog2(DEPTH):0]   Q_COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] ir_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic            pop;
    logic            wr;
    logic [CW:0]     credit;
    logic            issue_ok;
    logic [XLEN-1:0] redirect_al;

    assign redirect_al = REDIRECT_PC & ~(XLEN'(3));
    assign pop         = DE_VALID & DE_READY & ~REDIRECT;
    assign wr          = inflight & ~REDIRECT;

    // Slots already promised (held + in flight, minus the one leaving) must leave room
    // for the word this cycle's request will return next cycle.
    assign credit   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue_ok = credit < (CW+1)'(DEPTH);

    assign IMEM_RDEN = ~RESET & (REDIRECT | issue_ok);
    assign IMEM_ADDR = REDIRECT ? redirect_al[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2];

    assign DE_VALID  = (count != '0);
    assign DE_IR     = ir_mem[rd_ptr];
    assign DE_PC     = pc_mem[rd_ptr];
    assign DE_PC_INC = DE_PC + XLEN'(4);
    assign Q_COUNT   = count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (REDIRECT) begin
            // Flush everything; the redirect target is issued this very cycle.
            inflight    <= 1'b1;
            inflight_pc <= redirect_al;
            fetch_pc    <= redirect_al + XLEN'(4);
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (issue_ok) begin
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end else begin
                inflight <= 1'b0;
            end
            if (wr)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr) begin
            ir_mem[wr_ptr] <= IMEM_DOUT;
            pc_mem[wr_ptr] <= inflight_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET)
            assert (count <= CW'(DEPTH));
    end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue (DEPTH=4) plus a randomized scoreboard phase
// run on DEPTH=2, 4 and 8 instances sharing the same control stimulus.
module tb_otter_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b0;

    logic        rden4, rden2, rden8;
    logic [13:0] addr4, addr2, addr8;
    logic [31:0] dout4, dout2, dout8;
    logic        valid4, valid2, valid8;
    logic [31:0] ir4, ir2, ir8, pc4, pc2, pc8, inc4, inc2, inc8;
    logic [2:0]  cnt4;
    logic [1:0]  cnt2;
    logic [3:0]  cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otter_fetch_queue #(.DEPTH(4)) d4 (
        .CLK(clk), .RESET(rst), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .IMEM_RDEN(rden4), .IMEM_ADDR(addr4), .IMEM_DOUT(dout4),
        .DE_VALID(valid4), .DE_READY(ready), .DE_IR(ir4), .DE_PC(pc4),
        .DE_PC_INC(inc4), .Q_COUNT(cnt4));

    otter_fetch_queue #(.DEPTH(2)) d2 (
        .CLK(clk), .RESET(rst), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .IMEM_RDEN(rden2), .IMEM_ADDR(addr2), .IMEM_DOUT(dout2),
        .DE_VALID(valid2), .DE_READY(ready), .DE_IR(ir2), .DE_PC(pc2),
        .DE_PC_INC(inc2), .Q_COUNT(cnt2));

    otter_fetch_queue #(.DEPTH(8)) d8 (
        .CLK(clk), .RESET(rst), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .IMEM_RDEN(rden8), .IMEM_ADDR(addr8), .IMEM_DOUT(dout8),
        .DE_VALID(valid8), .DE_READY(ready), .DE_IR(ir8), .DE_PC(pc8),
        .DE_PC_INC(inc8), .Q_COUNT(cnt8));

    // Instruction memory: word at address a reads as 0x5A000000 | a.
    always_ff @(posedge clk) begin
        if (rden4) dout4 <= 32'h5A00_0000 | 32'(addr4);
        if (rden2) dout2 <= 32'h5A00_0000 | 32'(addr2);
        if (rden8) dout8 <= 32'h5A00_0000 | 32'(addr8);
    end

    function automatic logic [31:0] exp_ir(input logic [31:0] pc);
        return 32'h5A00_0000 | 32'(pc[15:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst = rs;
        redirect = rd;
        redirect_pc = rpc;
        ready = rdy;
        #1;
    endtask

    task automatic reset_seq();
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 32'h40, 1'b1);
        chk("rst_rden", 32'(rden4), 32'd0);
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_count", 32'(cnt4), 32'd0);
    endtask

    task automatic sb(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] ir, input logic [31:0] inc, input int cnt,
                      input int depth, input logic rdy, input logic red,
                      input logic [31:0] tgt, inout logic [31:0] exp);
        chk({tag, "_cnt_le_depth"}, 32'(cnt <= depth), 32'd1);
        if (v && rdy && !red) begin
            chk({tag, "_pc"}, pc, exp);
            chk({tag, "_ir"}, ir, exp_ir(exp));
            chk({tag, "_inc"}, inc, exp + 32'd4);
            exp = exp + 32'd4;
        end
        if (red)
            exp = tgt & ~32'd3;
    endtask

    initial begin
        logic [31:0] e2, e4, e8, tgt;
        logic        rdy, red;

        // Reset release with decode always ready: one instruction per cycle from cycle 2.
        reset_seq();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("t1_rden", 32'(rden4), 32'd1);
            chk("t1_addr", 32'(addr4), 32'(c));
            if (c < 2) begin
                chk("t1_valid_early", 32'(valid4), 32'd0);
            end else begin
                chk("t1_valid", 32'(valid4), 32'd1);
                chk("t1_pc", pc4, 32'(4 * (c - 2)));
                chk("t1_ir", ir4, exp_ir(32'(4 * (c - 2))));
                chk("t1_inc", inc4, 32'(4 * (c - 2) + 4));
            end
        end

        // Decode stalled from cycle 0: queue fills to DEPTH and issue stops.
        reset_seq();
        for (int c = 0; c < 7; c++)
            drive(1'b0, 1'b0, '0, 1'b0);
        chk("t2_count_full", 32'(cnt4), 32'd4);
        chk("t2_rden_full", 32'(rden4), 32'd0);
        chk("t2_valid_full", 32'(valid4), 32'd1);
        chk("t2_head_full", pc4, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (k == 0) begin
                chk("t2_rden_resume", 32'(rden4), 32'd1);
                chk("t2_addr_resume", 32'(addr4), 32'd4);
            end
            chk("t2_valid_drain", 32'(valid4), 32'd1);
            chk("t2_pc_drain", pc4, 32'(4 * k));
            chk("t2_ir_drain", ir4, exp_ir(32'(4 * k)));
        end

        // Redirect with 3 entries queued and one read in flight.
        reset_seq();
        for (int c = 0; c < 4; c++)
            drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        chk("t3_count_before", 32'(cnt4), 32'd3);
        chk("t3_rden", 32'(rden4), 32'd1);
        chk("t3_addr", 32'(addr4), 32'h40);
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("t3_count_flushed", 32'(cnt4), 32'd0);
        chk("t3_valid_flushed", 32'(valid4), 32'd0);
        chk("t3_addr_next", 32'(addr4), 32'h41);
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("t3_valid_target", 32'(valid4), 32'd1);
        chk("t3_pc_target", pc4, 32'h100);
        chk("t3_count_target", 32'(cnt4), 32'd1);

        // Redirect while head is being accepted, then back-to-back redirects.
        drive(1'b0, 1'b1, 32'h200, 1'b1);
        chk("t4_count_pre", 32'(cnt4), 32'd2);
        chk("t4_head_pre", pc4, 32'h100);
        chk("t4_addr_200", 32'(addr4), 32'h80);
        drive(1'b0, 1'b1, 32'h300, 1'b1);
        chk("t4_count_flush", 32'(cnt4), 32'd0);
        chk("t4_valid_flush", 32'(valid4), 32'd0);
        chk("t4_addr_300", 32'(addr4), 32'hC0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("t4_valid_gap", 32'(valid4), 32'd0);
        chk("t4_count_gap", 32'(cnt4), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("t4_valid_300", 32'(valid4), 32'd1);
            chk("t4_pc_300", pc4, 32'h300 + 32'(4 * k));
        end

        // Misaligned redirect near the top of the address space: PC+4 wraps.
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        chk("tw_addr", 32'(addr4), 32'h3FFF);
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("tw_pc_top", pc4, 32'hFFFF_FFFC);
        chk("tw_inc_wrap", inc4, 32'h0);
        chk("tw_ir_top", ir4, 32'h5A00_3FFF);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("tw_pc_wrapped", pc4, 32'h0);
        chk("tw_inc_after", inc4, 32'h4);

        // Reset dominates a simultaneous redirect while the queue is full.
        for (int c = 0; c < 8; c++)
            drive(1'b0, 1'b0, '0, 1'b0);
        chk("t5_count_full", 32'(cnt4), 32'd4);
        drive(1'b1, 1'b1, 32'h500, 1'b1);
        chk("t5_rden_in_reset", 32'(rden4), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("t5_count", 32'(cnt4), 32'd0);
        chk("t5_valid", 32'(valid4), 32'd0);
        chk("t5_rden", 32'(rden4), 32'd1);
        chk("t5_addr", 32'(addr4), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("t5_valid_c1", 32'(valid4), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("t5_valid_c2", 32'(valid4), 32'd1);
        chk("t5_pc_c2", pc4, 32'd0);

        // Random ready/redirect against an architectural PC-stream scoreboard.
        reset_seq();
        e2 = '0;
        e4 = '0;
        e8 = '0;
        for (int n = 0; n < 600; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            red = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'h0000_FFFF;
            drive(1'b0, red, tgt, rdy);
            sb("r2", valid2, pc2, ir2, inc2, int'(cnt2), 2, rdy, red, tgt, e2);
            sb("r4", valid4, pc4, ir4, inc4, int'(cnt4), 4, rdy, red, tgt, e4);
            sb("r8", valid8, pc8, ir8, inc8, int'(cnt8), 8, rdy, red, tgt, e8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
